// File: rtl/adpll_csr_pkg.sv
// Shared constants, status bit positions and hop FSM state type for adpll_csr.
package adpll_csr_pkg;

  // Word addresses
  localparam int unsigned ADDR_CTRL     = 0;
  localparam int unsigned ADDR_FCW      = 1;
  localparam int unsigned ADDR_LOOP_CFG = 2;
  localparam int unsigned ADDR_HOP      = 3;
  localparam int unsigned ADDR_STATUS   = 4;
  localparam int unsigned ADDR_IRQ_EN   = 5;
  localparam int unsigned ADDR_LOCK_TO  = 6;
  localparam int unsigned ADDR_TABLE    = 8;

  // CTRL bit positions
  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_SRST     = 3;

  // STATUS bit positions
  localparam int unsigned ST_LOCK       = 0;
  localparam int unsigned ST_SAT        = 1;
  localparam int unsigned ST_LOCK_STK   = 2;
  localparam int unsigned ST_SAT_STK    = 3;
  localparam int unsigned ST_HOP_DONE   = 4;
  localparam int unsigned ST_HOP_TO     = 5;

  typedef enum logic [1:0] {
    IDLE,
    DROP,
    LOAD,
    WAIT
  } hop_state_t;

  localparam logic [25:0] FCW_RST = 26'h2620000;

  // {alpha_l, alpha_m, alpha_s_rx, alpha_s_tx, beta, lambda_rx, lambda_tx, iir_n_rx, iir_n_tx}
  localparam logic [31:0] LOOP_CFG_RST = {4'd14, 4'd8, 4'd7, 4'd4, 4'd0,
                                          3'd2, 3'd2, 3'd3, 3'd2};

endpackage

// File: rtl/adpll_hop_fsm.sv
// Channel-hop sequencer: drop enable, load preset, re-enable and wait for lock.
module adpll_hop_fsm
  import adpll_csr_pkg::*;
#(
  parameter int unsigned IDX_W = 2,
  parameter int unsigned TO_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] start_idx,
  input  logic             abort,
  input  logic             lock,
  input  logic [TO_W-1:0]  lock_to,
  output logic             busy,
  output logic             load,
  output logic             drive_low,
  output logic             drive_high,
  output logic             done,
  output logic             timeout,
  output logic [IDX_W-1:0] cur_idx
);

  hop_state_t      state, state_nx;
  logic [TO_W-1:0] cnt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Latch the target index when a hop starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cur_idx <= '0;
    else if (start) cur_idx <= start_idx;
  end

  // Lock-wait counter: zero outside WAIT, so WAIT always begins at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (state == WAIT)  cnt <= cnt + TO_W'(1);
    else                     cnt <= '0;
  end

  // Next state, one-cycle done/timeout pulses; lock beats timeout, abort beats all
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: if (start) state_nx = DROP;
      DROP: state_nx = LOAD;
      LOAD: state_nx = WAIT;
      WAIT: begin
        if (lock) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (cnt == lock_to) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx = IDLE;
      done     = 1'b0;
      timeout  = 1'b0;
    end
  end

  // Enable override and status decode
  always_comb begin
    busy       = (state != IDLE);
    load       = (state == LOAD);
    drive_low  = (state == DROP) || (state == LOAD);
    drive_high = (state == WAIT);
  end

endmodule

// File: rtl/adpll_csr.sv
// ADPLL CPU register block: loop config, preset FCW table, hop sequencer, sticky status, irq.
module adpll_csr
  import adpll_csr_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned FCW_W    = 26,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned SRST_CYC = 4,
  parameter int unsigned TO_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wstrb,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  input  logic              channel_lock,
  input  logic              channel_sat,
  output logic              adpll_en,
  output logic              adpll_soft_rst,
  output logic [1:0]        adpll_mode,
  output logic [FCW_W-1:0]  fcw,
  output logic [31:0]       loop_cfg,
  output logic              irq
);

  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned SR_W  = $clog2(SRST_CYC + 1);

  logic              accept, wr_en;
  logic [31:0]       addr32;
  logic              sel_ctrl, sel_fcw, sel_cfg, sel_hop;
  logic              sel_status, sel_irqen, sel_lockto, sel_tbl;
  logic [IDX_W-1:0]  tbl_idx;
  logic              hop_start, srst_wr, ctrl_wr, fcw_wr;

  logic              ctrl_en;
  logic [1:0]        ctrl_mode;
  logic [FCW_W-1:0]  fcw_q;
  logic [31:0]       loop_cfg_q;
  logic [TO_W-1:0]   lock_to_q;
  logic [3:0]        irq_en_q;
  logic [3:0]        sticky;
  logic [3:0]        sticky_set, sticky_clr;
  logic [5:0]        status_vec;
  logic [SR_W-1:0]   srst_cnt;
  logic [FCW_W-1:0]  tbl [N_CH];
  logic [DATA_W-1:0] rd_mux;

  logic              busy, fsm_load, fsm_low, fsm_high, hop_done, hop_to;
  logic [IDX_W-1:0]  cur_idx;

  assign accept = valid & ~ready;
  assign wr_en  = accept & wstrb;
  assign addr32 = 32'(address);

  assign sel_ctrl   = (addr32 == ADDR_CTRL);
  assign sel_fcw    = (addr32 == ADDR_FCW);
  assign sel_cfg    = (addr32 == ADDR_LOOP_CFG);
  assign sel_hop    = (addr32 == ADDR_HOP);
  assign sel_status = (addr32 == ADDR_STATUS);
  assign sel_irqen  = (addr32 == ADDR_IRQ_EN);
  assign sel_lockto = (addr32 == ADDR_LOCK_TO);
  assign sel_tbl    = (addr32 >= ADDR_TABLE) && (addr32 < ADDR_TABLE + N_CH);
  assign tbl_idx    = IDX_W'(addr32 - ADDR_TABLE);

  // Full-width index compare so out-of-range indices are not aliased by truncation
  assign hop_start = wr_en & sel_hop & ~busy & (wdata < DATA_W'(N_CH));
  // Soft reset is honoured even while busy; the other CTRL fields are not
  assign srst_wr   = wr_en & sel_ctrl & wdata[CTRL_SRST];
  assign ctrl_wr   = wr_en & sel_ctrl & ~busy;
  assign fcw_wr    = wr_en & sel_fcw & ~busy;

  adpll_hop_fsm #(
    .IDX_W(IDX_W),
    .TO_W (TO_W)
  ) u_hop (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (hop_start),
    .start_idx (wdata[IDX_W-1:0]),
    .abort     (srst_wr),
    .lock      (channel_lock),
    .lock_to   (lock_to_q),
    .busy      (busy),
    .load      (fsm_load),
    .drive_low (fsm_low),
    .drive_high(fsm_high),
    .done      (hop_done),
    .timeout   (hop_to),
    .cur_idx   (cur_idx)
  );

  // Registered handshake: one-cycle ready with read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= accept;
      rdata <= accept ? rd_mux : '0;
    end
  end

  // Configuration registers; hop completion owns CTRL.en and the FCW load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en    <= 1'b0;
      ctrl_mode  <= '0;
      fcw_q      <= FCW_W'(FCW_RST);
      loop_cfg_q <= LOOP_CFG_RST;
      lock_to_q  <= '1;
      irq_en_q   <= '0;
    end else begin
      if (hop_done)     ctrl_en <= 1'b1;
      else if (hop_to)  ctrl_en <= 1'b0;
      else if (ctrl_wr) ctrl_en <= wdata[CTRL_EN];
      if (ctrl_wr) ctrl_mode <= wdata[CTRL_MODE_LSB +: 2];
      if (fsm_load)    fcw_q <= tbl[cur_idx];
      else if (fcw_wr) fcw_q <= wdata[FCW_W-1:0];
      if (wr_en && sel_cfg)    loop_cfg_q <= wdata[31:0];
      if (wr_en && sel_lockto) lock_to_q  <= wdata[TO_W-1:0];
      if (wr_en && sel_irqen)  irq_en_q   <= wdata[ST_HOP_TO:ST_LOCK_STK];
    end
  end

  // Preset channel table, writable at any time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) tbl[i] <= FCW_W'(FCW_RST);
    end else begin
      for (int unsigned i = 0; i < N_CH; i++)
        if (wr_en && sel_tbl && (tbl_idx == IDX_W'(i))) tbl[i] <= wdata[FCW_W-1:0];
    end
  end

  assign sticky_set = {hop_to, hop_done, channel_sat, channel_lock};
  assign sticky_clr = (wr_en && sel_status) ? wdata[ST_HOP_TO:ST_LOCK_STK] : '0;

  // Sticky status (set wins over W1C) and registered interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= '0;
      irq    <= 1'b0;
    end else begin
      sticky <= (sticky & ~sticky_clr) | sticky_set;
      irq    <= |(sticky & irq_en_q);
    end
  end

  // Soft-reset pulse counter; a repeat write reloads it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              srst_cnt <= '0;
    else if (srst_wr)        srst_cnt <= SR_W'(SRST_CYC);
    else if (srst_cnt != '0) srst_cnt <= srst_cnt - SR_W'(1);
  end

  // Read data mux; unmapped addresses read all ones
  always_comb begin
    status_vec              = '0;
    status_vec[ST_LOCK]     = channel_lock;
    status_vec[ST_SAT]      = channel_sat;
    status_vec[ST_LOCK_STK] = sticky[0];
    status_vec[ST_SAT_STK]  = sticky[1];
    status_vec[ST_HOP_DONE] = sticky[2];
    status_vec[ST_HOP_TO]   = sticky[3];
    rd_mux = '1;
    if (sel_ctrl)        rd_mux = DATA_W'({ctrl_mode, ctrl_en});
    else if (sel_fcw)    rd_mux = DATA_W'(fcw_q);
    else if (sel_cfg)    rd_mux = DATA_W'(loop_cfg_q);
    else if (sel_hop)    rd_mux = DATA_W'({4'(cur_idx), 3'b000, busy});
    else if (sel_status) rd_mux = DATA_W'(status_vec);
    else if (sel_irqen)  rd_mux = DATA_W'({irq_en_q, 2'b00});
    else if (sel_lockto) rd_mux = DATA_W'(lock_to_q);
    else if (sel_tbl)    rd_mux = DATA_W'(tbl[tbl_idx]);
  end

  assign adpll_soft_rst = (srst_cnt != '0);
  assign adpll_en       = fsm_high | (~fsm_low & ctrl_en & ~adpll_soft_rst);
  assign adpll_mode     = ctrl_mode;
  assign fcw            = fcw_q;
  assign loop_cfg       = loop_cfg_q;

endmodule
